serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
- Bit-serial subtractor that computes DIFF = A − B, LSB first, one bit per clock, using a single full-subtractor cell and a borrow flop.
- It is the inverse-direction companion to the team's ripple-carry adder datapath, and the first sequential arithmetic unit in the switch/LED lab series.
- Operands are captured on a start pulse. A done pulse marks when the registered result and borrow-out are valid.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range 2..16.
- CNT_W, 5, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- CLOCK_50  input  1  system clock; all logic is rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  minuend (unsigned); sampled on the start-accept edge.
- B  input  WIDTH  subtrahend (unsigned); sampled on the start-accept edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; DIFF and BOUT are valid from this cycle on.
- DIFF  output  WIDTH  registered result, A − B mod 2^WIDTH.
- BOUT  output  1  registered borrow-out; 1 when A < B (unsigned).

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, DIFF=0, BOUT=0, counter=0, borrow flop=0, shift registers=0.
- States: IDLE and RUN only.
- IDLE + start=1 at an edge:
  - load shift registers sa←A, sb←B; clear the result shift register sr, borrow br←0 and cnt←0;
  - go to RUN; busy=1 from the next cycle.
- RUN, each edge:
  - d = sa[0]^sb[0]^br;
  - br ← (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&br);
  - sa and sb shift right; sr shifts right with d entering at MSB; cnt++.
- RUN completion, on the edge where cnt==WIDTH−1 (the WIDTH-th bit):
  - DIFF ← final value of sr including the incoming bit d; BOUT ← final borrow;
  - done ← 1; state → IDLE.
- Latency: done is high in the cycle that follows exactly WIDTH edges after the accept edge.
- done is registered and high for exactly one cycle; it deasserts on the next edge unless another completion occurs.
- busy equals (state==RUN).
- DIFF and BOUT hold their value until the next completion. They do not change during RUN, so the previous result stays readable while busy.
- start while busy=1: ignored, with no effect on the operation in progress.
- start asserted in the done cycle: the block is already in IDLE, so start is accepted. Back-to-back operations have one cycle of issue spacing beyond WIDTH.
- start held high continuously: a new operation is accepted every WIDTH+1 cycles.
- A and B may change freely after the accept edge.
- reset asserted mid-RUN: the operation is aborted, all state returns to reset values, and no done pulse is produced.
- reset has priority over start on the same edge.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - adds output port OVF (1 bit, reset 0), registered alongside DIFF;
  - OVF = two's-complement signed overflow of A − B: (A[MSB]≠B[MSB]) && (DIFF[MSB]≠A[MSB]);
  - A[MSB] and B[MSB] are captured at accept; OVF is updated only at completion.
- Not defined: OVF does not exist; no extra flops.
- Unsigned behaviour is identical in both builds.

Test Plan:
- Reset, then start with A=9, B=3 (WIDTH=4) -> busy=1 for 4 cycles; done pulses once, 4 edges after accept; DIFF=6, BOUT=0.
- A=3, B=9 -> DIFF=4'hA, BOUT=1. Then A=0,B=0 -> DIFF=0,BOUT=0. Then A=15,B=15 -> DIFF=0,BOUT=0. Then A=0,B=1 -> DIFF=4'hF,BOUT=1.
- Start A=12,B=5; pulse start with A=1,B=1 two cycles later -> second start ignored; DIFF=7, BOUT=0; exactly one done.
- Start A=8,B=2, then assert reset two cycles into RUN -> busy=0, DIFF=0, BOUT=0, no done; a subsequent start A=8,B=2 gives DIFF=6.
- start held high with A=5,B=7 -> done every 5 cycles; DIFF=4'hE, BOUT=1 each time; DIFF keeps its previous value while busy.
- SERIAL_SUB_OVF_EN build, A=4'b0111, B=4'b1000 -> DIFF=4'hF, BOUT=1, OVF=1. Then A=6,B=2 -> OVF=0.

Source files
------------

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial subtractor, DIFF = A - B, LSB first, one bit per
//               clock. It uses one full-subtractor cell and a borrow flop.
//               Operands are captured on a start pulse. A one-cycle done
//               pulse marks a new registered DIFF/BOUT.
//               Define SERIAL_SUB_OVF_EN to add the signed-overflow output OVF.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 4,   // operand/result width, 2..16
    parameter int CNT_W = 5    // bit-counter width, 2**CNT_W > WIDTH
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] DIFF,
    output logic             BOUT
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             OVF
`endif
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    logic [0:0]       r_state;
    logic [0:0]       w_next_state;

    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_sr;
    logic             r_br;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_done;

    logic             w_accept;
    logic             w_last;
    logic             w_d;
    logic             w_br_next;
    logic [WIDTH-1:0] w_sr_next;

    // Full-subtractor cell working on the current LSBs plus the borrow flop.
    assign w_d       = r_sa[0] ^ r_sb[0] ^ r_br;
    assign w_br_next = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_br);
    assign w_sr_next = {w_d, r_sr[WIDTH-1:1]};

    assign w_accept  = (r_state == S_IDLE) && start;
    assign w_last    = (r_state == S_RUN) && (r_cnt == c_last_bit);

    // State register.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: leave IDLE on start, return after the last bit.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_next_state = S_RUN;
            S_RUN:   if (w_last) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy = (r_state == S_RUN);
    end

    // Serial datapath: capture operands at accept, then shift one bit per cycle.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_sa  <= '0;
            r_sb  <= '0;
            r_sr  <= '0;
            r_br  <= 1'b0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_sa  <= A;
            r_sb  <= B;
            r_sr  <= '0;
            r_br  <= 1'b0;
            r_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_sa  <= {1'b0, r_sa[WIDTH-1:1]};
            r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
            r_sr  <= w_sr_next;
            r_br  <= w_br_next;
            r_cnt <= r_cnt + c_cnt_one;
        end
    end

    // Result registers update only at completion, so the old result stays
    // readable while the next operation runs.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_diff <= '0;
            r_bout <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_last) begin
                r_diff <= w_sr_next;
                r_bout <= w_br_next;
            end
        end
    end

    assign done = r_done;
    assign DIFF = r_diff;
    assign BOUT = r_bout;

`ifdef SERIAL_SUB_OVF_EN
    logic r_amsb;
    logic r_bmsb;
    logic r_ovf;

    // Operand sign bits are captured at accept. Overflow is judged at completion
    // from the operand signs and the sign of the finished difference.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_amsb <= 1'b0;
            r_bmsb <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_amsb <= A[WIDTH-1];
                r_bmsb <= B[WIDTH-1];
            end
            if (w_last) begin
                r_ovf <= (r_amsb != r_bmsb) && (w_sr_next[WIDTH-1] != r_amsb);
            end
        end
    end

    assign OVF = r_ovf;
`endif

endmodule
`default_nettype wire
